// File: rtl/jtag_tap_param.sv
// jtag_tap_param -- parametrised IEEE 1149.1 TAP controller.
//
// Sits between the board JTAG pins and the core I/O ring. Provides the
// standard 16-state TAP FSM, an IR of IR_W bits, and BYPASS, IDCODE,
// USERCODE, boundary-scan (SAMPLE/EXTEST/INTEST), CLAMP and HIGHZ.
//
// Optional feature macro: JTAG_RUNBIST_EN
//   Defined   : opcode 4 (RUNBIST) selects a 16-bit LFSR signature register.
//   Undefined : opcode 4 decodes as BYPASS and no LFSR logic is built.
//
// Ports:
//   TCK      in   test clock; state on posedge, TDO/TDO_OE/IR/BSR update on negedge
//   TRST     in   asynchronous active-low reset
//   TMS      in   mode select
//   TDI      in   serial data in
//   TDO      out  serial data out (registered on negedge)
//   TDO_OE   out  high only while in Shift-IR / Shift-DR
//   pin_in   in   values from device pins
//   core_out in   core-driven values destined for pins
//   pin_out  out  values driven to pins
//   pin_oe   out  pin output enable (low only under HIGHZ)
//   core_in  out  values presented to core
module jtag_tap_param #(
    parameter int          IR_W         = 4,
    parameter int          BSR_W        = 8,
    parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
    parameter logic [31:0] USERCODE_VAL = 32'h0000_0000,
    parameter int          BIST_CYCLES  = 64
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             TDO_OE,
    input  logic [BSR_W-1:0] pin_in,
    input  logic [BSR_W-1:0] core_out,
    output logic [BSR_W-1:0] pin_out,
    output logic             pin_oe,
    output logic [BSR_W-1:0] core_in
);

    // Standard 1149.1 state encoding.
    localparam logic [3:0] ST_EX2DR = 4'h0;
    localparam logic [3:0] ST_EX1DR = 4'h1;
    localparam logic [3:0] ST_SHDR  = 4'h2;
    localparam logic [3:0] ST_PAUDR = 4'h3;
    localparam logic [3:0] ST_SELIR = 4'h4;
    localparam logic [3:0] ST_UPDDR = 4'h5;
    localparam logic [3:0] ST_CAPDR = 4'h6;
    localparam logic [3:0] ST_SELDR = 4'h7;
    localparam logic [3:0] ST_EX2IR = 4'h8;
    localparam logic [3:0] ST_EX1IR = 4'h9;
    localparam logic [3:0] ST_SHIR  = 4'hA;
    localparam logic [3:0] ST_PAUIR = 4'hB;
    localparam logic [3:0] ST_RTI   = 4'hC;
    localparam logic [3:0] ST_UPDIR = 4'hD;
    localparam logic [3:0] ST_CAPIR = 4'hE;
    localparam logic [3:0] ST_TLR   = 4'hF;

    localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(32'd7);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(32'd1);

    // Zero-extends both sides so opcodes compare correctly for any IR_W.
    function automatic logic op_is(input logic [IR_W-1:0] ir, input logic [7:0] code);
        logic [IR_W+7:0] a;
        logic [IR_W+7:0] b;
        a = {8'd0, ir};
        b = {{IR_W{1'b0}}, code};
        return (a == b) && !(&ir);
    endfunction

    function automatic logic [3:0] next_state(input logic [3:0] s, input logic tms);
        case (s)
            ST_TLR:   next_state = tms ? ST_TLR   : ST_RTI;
            ST_RTI:   next_state = tms ? ST_SELDR : ST_RTI;
            ST_SELDR: next_state = tms ? ST_SELIR : ST_CAPDR;
            ST_CAPDR: next_state = tms ? ST_EX1DR : ST_SHDR;
            ST_SHDR:  next_state = tms ? ST_EX1DR : ST_SHDR;
            ST_EX1DR: next_state = tms ? ST_UPDDR : ST_PAUDR;
            ST_PAUDR: next_state = tms ? ST_EX2DR : ST_PAUDR;
            ST_EX2DR: next_state = tms ? ST_UPDDR : ST_SHDR;
            ST_UPDDR: next_state = tms ? ST_SELDR : ST_RTI;
            ST_SELIR: next_state = tms ? ST_TLR   : ST_CAPIR;
            ST_CAPIR: next_state = tms ? ST_EX1IR : ST_SHIR;
            ST_SHIR:  next_state = tms ? ST_EX1IR : ST_SHIR;
            ST_EX1IR: next_state = tms ? ST_UPDIR : ST_PAUIR;
            ST_PAUIR: next_state = tms ? ST_EX2IR : ST_PAUIR;
            ST_EX2IR: next_state = tms ? ST_UPDIR : ST_SHIR;
            ST_UPDIR: next_state = tms ? ST_SELDR : ST_RTI;
            default:  next_state = ST_TLR;
        endcase
    endfunction

    logic [3:0]       state_r;
    logic [IR_W-1:0]  ir_r;
    logic [IR_W-1:0]  ir_sh_r;
    logic             bypass_r;
    logic [31:0]      id_sh_r;
    logic [BSR_W-1:0] bsr_sh_r;
    logic [BSR_W-1:0] bsr_upd_r;

    logic op_sample_s, op_extest_s, op_intest_s, op_clamp_s, op_highz_s;
    logic sel_id_s, sel_user_s, sel_bsr_s, sel_bist_s;
    logic dr_lsb_s;

    // Instruction decode; anything unrecognised falls through to bypass.
    always_comb begin
        op_sample_s = op_is(ir_r, 8'd1);
        op_extest_s = op_is(ir_r, 8'd2);
        op_intest_s = op_is(ir_r, 8'd3);
        op_clamp_s  = op_is(ir_r, 8'd5);
        sel_id_s    = op_is(ir_r, 8'd7);
        sel_user_s  = op_is(ir_r, 8'd8);
        op_highz_s  = op_is(ir_r, 8'd9);
        sel_bsr_s   = op_sample_s | op_extest_s | op_intest_s;
`ifdef JTAG_RUNBIST_EN
        sel_bist_s  = op_is(ir_r, 8'd4);
`else
        sel_bist_s  = 1'b0;
`endif
    end

    // TAP state register.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_r <= ST_TLR;
        end else begin
            state_r <= next_state(state_r, TMS);
        end
    end

    // IR shift stage: capture 0..01, shift LSB-first with TDI entering the MSB.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sh_r <= '0;
        end else if (state_r == ST_CAPIR) begin
            ir_sh_r <= IR_CAPTURE;
        end else if (state_r == ST_SHIR) begin
            ir_sh_r <= {TDI, ir_sh_r[IR_W-1:1]};
        end else begin
            ir_sh_r <= ir_sh_r;
        end
    end

    // Data register shift stages; only the selected DR captures or shifts.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bypass_r <= 1'b0;
            id_sh_r  <= 32'd0;
            bsr_sh_r <= '0;
        end else if (state_r == ST_CAPDR) begin
            bypass_r <= 1'b0;
            id_sh_r  <= sel_user_s ? USERCODE_VAL : IDCODE_VAL;
            if (sel_bsr_s) begin
                bsr_sh_r <= op_intest_s ? core_out : pin_in;
            end else begin
                bsr_sh_r <= bsr_sh_r;
            end
        end else if (state_r == ST_SHDR) begin
            bypass_r <= TDI;
            id_sh_r  <= (sel_id_s | sel_user_s) ? {TDI, id_sh_r[31:1]} : id_sh_r;
            bsr_sh_r <= sel_bsr_s ? {TDI, bsr_sh_r[BSR_W-1:1]} : bsr_sh_r;
        end else begin
            bypass_r <= bypass_r;
            id_sh_r  <= id_sh_r;
            bsr_sh_r <= bsr_sh_r;
        end
    end

`ifdef JTAG_RUNBIST_EN
    localparam int CNT_W = $clog2(BIST_CYCLES + 1);
    logic [15:0]      lfsr_r;
    logic [15:0]      sig_sh_r;
    logic [CNT_W-1:0] bist_cnt_r;

    // LFSR x^16+x^14+x^13+x^11+1 (right-shifting form); reseeds when RUNBIST
    // is loaded, then steps in RTI until BIST_CYCLES steps have been taken.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            lfsr_r     <= 16'hACE1;
            bist_cnt_r <= '0;
        end else if ((state_r == ST_UPDIR) && op_is(ir_sh_r, 8'd4)) begin
            lfsr_r     <= 16'hACE1;
            bist_cnt_r <= '0;
        end else if ((state_r == ST_RTI) && sel_bist_s && (bist_cnt_r < CNT_W'(BIST_CYCLES))) begin
            lfsr_r     <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
            bist_cnt_r <= bist_cnt_r + CNT_W'(1);
        end else begin
            lfsr_r     <= lfsr_r;
            bist_cnt_r <= bist_cnt_r;
        end
    end

    // Signature shift register: captures the LFSR and shifts it out.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            sig_sh_r <= 16'd0;
        end else if ((state_r == ST_CAPDR) && sel_bist_s) begin
            sig_sh_r <= lfsr_r;
        end else if ((state_r == ST_SHDR) && sel_bist_s) begin
            sig_sh_r <= {TDI, sig_sh_r[15:1]};
        end else begin
            sig_sh_r <= sig_sh_r;
        end
    end
`endif

    // LSB of the currently selected data register.
    always_comb begin
        if (sel_bsr_s) begin
            dr_lsb_s = bsr_sh_r[0];
        end else if (sel_id_s | sel_user_s) begin
            dr_lsb_s = id_sh_r[0];
`ifdef JTAG_RUNBIST_EN
        end else if (sel_bist_s) begin
            dr_lsb_s = sig_sh_r[0];
`endif
        end else begin
            dr_lsb_s = bypass_r;
        end
    end

    // Falling-edge IR update; TLR forces IDCODE so aborted scans never leak.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_r <= OP_IDCODE;
        end else if (state_r == ST_TLR) begin
            ir_r <= OP_IDCODE;
        end else if (state_r == ST_UPDIR) begin
            ir_r <= ir_sh_r;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Falling-edge BSR update stage; persists across IR changes, cleared in TLR.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            bsr_upd_r <= '0;
        end else if (state_r == ST_TLR) begin
            bsr_upd_r <= '0;
        end else if ((state_r == ST_UPDDR) && sel_bsr_s) begin
            bsr_upd_r <= bsr_sh_r;
        end else begin
            bsr_upd_r <= bsr_upd_r;
        end
    end

    // TDO and its enable, launched on the falling edge.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            TDO    <= 1'b0;
            TDO_OE <= 1'b0;
        end else begin
            case (state_r)
                ST_SHIR: begin
                    TDO    <= ir_sh_r[0];
                    TDO_OE <= 1'b1;
                end
                ST_SHDR: begin
                    TDO    <= dr_lsb_s;
                    TDO_OE <= 1'b1;
                end
                default: begin
                    TDO    <= 1'b0;
                    TDO_OE <= 1'b0;
                end
            endcase
        end
    end

    // Pin / core muxing. CLAMP (and RUNBIST) hold the pins at the update stage.
    always_comb begin
        if (op_extest_s | op_clamp_s | sel_bist_s) begin
            pin_out = bsr_upd_r;
        end else begin
            pin_out = core_out;
        end
        if (op_intest_s) begin
            core_in = bsr_upd_r;
        end else begin
            core_in = pin_in;
        end
        pin_oe = !op_highz_s;
    end

endmodule

// File: tb/tb_jtag_tap_param.sv
module tb_jtag_tap_param;

    logic       TCK;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic       TDO;
    logic       TDO_OE;
    logic [7:0] pin_in;
    logic [7:0] core_out;
    logic [7:0] pin_out;
    logic       pin_oe;
    logic [7:0] core_in;

    int checks;
    int errors;
    logic tdo_v;
    logic oe_v;

    jtag_tap_param dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_OE(TDO_OE),
        .pin_in(pin_in), .core_out(core_out), .pin_out(pin_out),
        .pin_oe(pin_oe), .core_in(core_in)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // One TCK: drive TMS/TDI, take the rising edge, sample after the falling edge.
    task automatic tck(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
        tdo_v = TDO;
        oe_v  = TDO_OE;
    endtask

    // Called in a shift state with the first bit already on TDO; exits in Exit1.
    task automatic shift_bits(input int n, input logic [31:0] din,
                              output logic [31:0] dout, output logic oe_all);
        dout   = 32'd0;
        oe_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo_v;
            oe_all  = oe_all & oe_v;
            tck((i == n - 1), din[i]);
        end
    endtask

    // RTI -> DR scan of n bits -> RTI.
    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic oe_all;
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
        shift_bits(n, din, dout, oe_all);
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
    endtask

    // RTI -> IR scan (4 bits) -> RTI.
    task automatic ir_scan(input logic [3:0] din, output logic [3:0] dout);
        logic [31:0] d;
        logic oe_all;
        tck(1'b1, 1'b0);
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
        shift_bits(4, {28'd0, din}, d, oe_all);
        dout = d[3:0];
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic oe_all;
        TRST = 1'b0;
        repeat (2) @(posedge TCK);
        #1;
        checks++;
        if (TDO !== 1'b0 || TDO_OE !== 1'b0) begin
            errors++;
            $display("FAIL reset_tdo got tdo=%b oe=%b exp 0 0", TDO, TDO_OE);
        end
        checks++;
        if (pin_oe !== 1'b1 || pin_out !== core_out) begin
            errors++;
            $display("FAIL reset_pins got oe=%b pin_out=%h exp 1 %h", pin_oe, pin_out, core_out);
        end
        @(negedge TCK);
        TRST = 1'b1;
        tck(1'b0, 1'b0);
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
        shift_bits(32, 32'd0, d, oe_all);
        checks++;
        if (d !== 32'h1000_0001) begin
            errors++;
            $display("FAIL idcode got %h exp 10000001", d);
        end
        checks++;
        if (oe_all !== 1'b1 || oe_v !== 1'b0) begin
            errors++;
            $display("FAIL tdo_oe got shift=%b exit1=%b exp 1 0", oe_all, oe_v);
        end
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
    endtask

    task automatic test_ir();
        logic [3:0]  c;
        logic [31:0] d;
        ir_scan(4'h6, c);
        checks++;
        if (c !== 4'b0001) begin
            errors++;
            $display("FAIL ir_capture got %b exp 0001", c);
        end
        dr_scan(8, 32'h01, d);
        checks++;
        if (d[7:0] !== 8'h02) begin
            errors++;
            $display("FAIL undef_len got %h exp 02", d[7:0]);
        end
    endtask

    task automatic test_bypass();
        logic [3:0]  c;
        logic [31:0] d;
        ir_scan(4'hF, c);
        dr_scan(10, 32'h204, d);
        checks++;
        if (d[9:0] !== 10'h008) begin
            errors++;
            $display("FAIL bypass got %h exp 008", d[9:0]);
        end
        checks++;
        if (pin_out !== core_out || pin_oe !== 1'b1) begin
            errors++;
            $display("FAIL bypass_pins got %h/%b exp %h/1", pin_out, pin_oe, core_out);
        end
    endtask

    task automatic test_sample_extest();
        logic [3:0]  c;
        logic [31:0] d;
        pin_in   = 8'hA5;
        core_out = 8'h11;
        ir_scan(4'h1, c);
        dr_scan(8, 32'h6F, d);
        checks++;
        if (d[7:0] !== 8'hA5) begin
            errors++;
            $display("FAIL sample_cap got %h exp a5", d[7:0]);
        end
        checks++;
        if (pin_out !== 8'h11) begin
            errors++;
            $display("FAIL sample_pins got %h exp 11", pin_out);
        end
        ir_scan(4'h2, c);
        checks++;
        if (pin_out !== 8'h6F) begin
            errors++;
            $display("FAIL extest_hold got %h exp 6f", pin_out);
        end
        dr_scan(8, 32'h6F, d);
        checks++;
        if (d[7:0] !== 8'hA5 || pin_out !== 8'h6F) begin
            errors++;
            $display("FAIL extest got cap=%h pin_out=%h exp a5 6f", d[7:0], pin_out);
        end
        ir_scan(4'h5, c);
        checks++;
        if (pin_out !== 8'h6F || pin_oe !== 1'b1) begin
            errors++;
            $display("FAIL clamp got %h/%b exp 6f/1", pin_out, pin_oe);
        end
        ir_scan(4'h9, c);
        checks++;
        if (pin_oe !== 1'b0 || pin_out !== 8'h11) begin
            errors++;
            $display("FAIL highz got oe=%b pin_out=%h exp 0 11", pin_oe, pin_out);
        end
    endtask

    task automatic test_intest();
        logic [3:0]  c;
        logic [31:0] d;
        core_out = 8'h3C;
        ir_scan(4'h3, c);
        dr_scan(8, 32'h81, d);
        checks++;
        if (d[7:0] !== 8'h3C) begin
            errors++;
            $display("FAIL intest_cap got %h exp 3c", d[7:0]);
        end
        checks++;
        if (core_in !== 8'h81 || pin_out !== 8'h3C) begin
            errors++;
            $display("FAIL intest_upd got core_in=%h pin_out=%h exp 81 3c", core_in, pin_out);
        end
        ir_scan(4'hF, c);
        checks++;
        if (core_in !== 8'hA5) begin
            errors++;
            $display("FAIL intest_release got %h exp a5", core_in);
        end
    endtask

    task automatic test_runbist_off();
        logic [3:0]  c;
        logic [31:0] d;
        ir_scan(4'h4, c);
        dr_scan(8, 32'h01, d);
`ifndef JTAG_RUNBIST_EN
        checks++;
        if (d[7:0] !== 8'h02) begin
            errors++;
            $display("FAIL runbist_bypass got %h exp 02", d[7:0]);
        end
`endif
    endtask

    task automatic test_abort();
        logic [3:0]  c;
        logic [31:0] d;
        ir_scan(4'h2, c);
        checks++;
        if (pin_out !== 8'h81) begin
            errors++;
            $display("FAIL abort_pre got %h exp 81", pin_out);
        end
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tck(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
        checks++;
        if (pin_out !== 8'h3C || pin_oe !== 1'b1 || oe_v !== 1'b0) begin
            errors++;
            $display("FAIL tms_abort got %h/%b/%b exp 3c/1/0", pin_out, pin_oe, oe_v);
        end
        tck(1'b0, 1'b0);
        dr_scan(32, 32'd0, d);
        checks++;
        if (d !== 32'h1000_0001) begin
            errors++;
            $display("FAIL tms_abort_ir got %h exp 10000001", d);
        end
        ir_scan(4'h2, c);
        checks++;
        if (pin_out !== 8'h00) begin
            errors++;
            $display("FAIL tms_abort_upd got %h exp 00", pin_out);
        end
        dr_scan(8, 32'hFF, d);
        checks++;
        if (pin_out !== 8'hFF) begin
            errors++;
            $display("FAIL trst_pre got %h exp ff", pin_out);
        end
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tck(1'b0, 1'b0);
        TRST = 1'b0;
        #1;
        checks++;
        if (pin_out !== 8'h3C || pin_oe !== 1'b1 || TDO_OE !== 1'b0 || TDO !== 1'b0) begin
            errors++;
            $display("FAIL trst_abort got %h/%b/%b/%b exp 3c/1/0/0", pin_out, pin_oe, TDO_OE, TDO);
        end
        #1;
        TRST = 1'b1;
        tck(1'b0, 1'b0);
        dr_scan(32, 32'd0, d);
        checks++;
        if (d !== 32'h1000_0001) begin
            errors++;
            $display("FAIL trst_abort_ir got %h exp 10000001", d);
        end
        ir_scan(4'h2, c);
        checks++;
        if (pin_out !== 8'h00) begin
            errors++;
            $display("FAIL trst_abort_upd got %h exp 00", pin_out);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        tdo_v    = 1'b0;
        oe_v     = 1'b0;
        TRST     = 1'b0;
        TMS      = 1'b1;
        TDI      = 1'b0;
        pin_in   = 8'h00;
        core_out = 8'h00;
        test_reset();
        test_ir();
        test_bypass();
        test_sample_extest();
        test_intest();
        test_runbist_off();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
